// File: rtl/at_access_sched_pkg.sv
// Shared MMU AND-tree widths plus the scheduler's update-entry and tracker types.
// Every block that touches the AND-tree imports these widths from here.
package at_access_sched_pkg;

  localparam int REQ_ID_WIDTH        = 8;
  localparam int AT_TREE_INDEX_WIDTH = 8;
  localparam int REQ_SIZE_TYPE_WIDTH = 3;
  localparam int AT_TREE_BIT_WIDTH   = 16;

  typedef struct packed {
    logic [AT_TREE_INDEX_WIDTH-1:0] column_idx;
    logic [AT_TREE_INDEX_WIDTH-1:0] row_idx;
    logic [AT_TREE_BIT_WIDTH-1:0]   bit_sequence;
  } upd_entry_t;

  localparam int UPD_ENTRY_W = $bits(upd_entry_t);

  typedef struct packed {
    logic                           valid;
    logic [AT_TREE_INDEX_WIDTH-1:0] row;
  } track_t;

  function automatic logic row_hit(input track_t t, input logic [AT_TREE_INDEX_WIDTH-1:0] row);
    return t.valid && (t.row == row);
  endfunction

endpackage

// File: rtl/at_upd_fifo.sv
// In-order update queue. Besides the head it exposes every entry's row and a
// live-entry mask so the scheduler can block searches against queued rows.
module at_upd_fifo
  import at_access_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      i_push,
  input  logic [UPD_ENTRY_W-1:0]                    i_data,
  input  logic                                      i_pop,
  output logic [UPD_ENTRY_W-1:0]                    o_data,
  output logic                                      o_full,
  output logic [$clog2(DEPTH):0]                    o_count,
  output logic [DEPTH-1:0]                          o_valid,
  output logic [DEPTH-1:0][AT_TREE_INDEX_WIDTH-1:0] o_rows
);

  localparam int PTR_W = $clog2(DEPTH);

  upd_entry_t       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  // A full queue refuses the push even if the head pops in the same cycle.
  assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & (r_count != '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage is not reset; the pointers and count alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= upd_entry_t'(i_data);
  end

  // NOTE: outputs get a default before the loop so the block can never infer a latch.
  always_comb begin
    o_valid = '0;
    o_rows  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_rows[i]  = r_mem[i].row_idx;
      o_valid[i] = ({1'b0, PTR_W'(i) - r_rd_ptr} < r_count);
    end
  end

endmodule

// File: rtl/at_access_sched.sv
// AND-tree access scheduler: queues row updates, spaces same-row read-modify-writes
// three cycles apart, and holds back searches whose row is queued or in flight.
module at_access_sched
  import at_access_sched_pkg::*;
#(
  parameter int UPD_FIFO_DEPTH  = 4,
  parameter int STALL_CNT_WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           alloc_req_valid,
  output logic                           alloc_req_ready,
  input  logic [REQ_ID_WIDTH-1:0]        alloc_req_id,
  input  logic [AT_TREE_INDEX_WIDTH-1:0] alloc_req_pos,
  input  logic [REQ_SIZE_TYPE_WIDTH-1:0] alloc_req_size,
  input  logic [REQ_SIZE_TYPE_WIDTH-1:0] alloc_req_origin_size,
  input  logic                           upd_req_valid,
  output logic                           upd_req_ready,
  input  logic [AT_TREE_INDEX_WIDTH-1:0] upd_req_column_idx,
  input  logic [AT_TREE_INDEX_WIDTH-1:0] upd_req_row_idx,
  input  logic [AT_TREE_BIT_WIDTH-1:0]   upd_req_bit_sequence,
  output logic                           alloc_valid_fdt_in,
  output logic [REQ_ID_WIDTH-1:0]        alloc_id_fdt_in,
  output logic [AT_TREE_INDEX_WIDTH-1:0] alloc_pos_fdt_in,
  output logic [REQ_SIZE_TYPE_WIDTH-1:0] alloc_size_fdt_in,
  output logic [REQ_SIZE_TYPE_WIDTH-1:0] alloc_origin_size_fdt_in,
  output logic                           at_tree_update_en,
  output logic [AT_TREE_INDEX_WIDTH-1:0] at_tree_update_column_idx,
  output logic [AT_TREE_INDEX_WIDTH-1:0] at_tree_update_row_idx,
  output logic [AT_TREE_BIT_WIDTH-1:0]   at_tree_update_bit_sequence,
  output logic                           sched_busy,
  output logic [STALL_CNT_WIDTH-1:0]     alloc_stall_cnt
);

  localparam int CNT_W = $clog2(UPD_FIFO_DEPTH) + 1;

  upd_entry_t                                        w_in;
  upd_entry_t                                        w_head;
  logic                                              w_push;
  logic                                              w_full;
  logic                                              w_queued;
  logic                                              w_issue;
  logic                                              w_fifo_hit;
  logic                                              w_blocked;
  logic [CNT_W-1:0]                                  w_count;
  logic [UPD_FIFO_DEPTH-1:0]                         w_valid;
  logic [UPD_FIFO_DEPTH-1:0][AT_TREE_INDEX_WIDTH-1:0] w_rows;
  track_t                                            w_s0;
  track_t                                            r_s1;
  track_t                                            r_s2;
  logic [STALL_CNT_WIDTH-1:0]                        r_stall_cnt;

  assign w_in          = '{column_idx: upd_req_column_idx, row_idx: upd_req_row_idx,
                           bit_sequence: upd_req_bit_sequence};
  assign upd_req_ready = ~w_full;
  assign w_push        = upd_req_valid & upd_req_ready;

  at_upd_fifo #(.DEPTH(UPD_FIFO_DEPTH)) u_upd_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_in),
    .i_pop   (w_issue),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_count (w_count),
    .o_valid (w_valid),
    .o_rows  (w_rows)
  );

  // Head waits while its row's previous read-modify-write is still in stages 1..2.
  assign w_queued = (w_count != '0);
  assign w_issue  = w_queued & ~row_hit(r_s1, w_head.row_idx) & ~row_hit(r_s2, w_head.row_idx);
  assign w_s0     = '{valid: w_issue, row: w_head.row_idx};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= w_s0;
      r_s2 <= r_s1;
    end
  end

  always_comb begin
    w_fifo_hit = 1'b0;
    for (int i = 0; i < UPD_FIFO_DEPTH; i++) begin
      if (w_valid[i] && (w_rows[i] == alloc_req_pos)) w_fifo_hit = 1'b1;
    end
  end

  // A search must not observe a row that is queued, being accepted now, or mid-RMW.
  assign w_blocked = w_fifo_hit
                   | (w_push && (upd_req_row_idx == alloc_req_pos))
                   | row_hit(w_s0, alloc_req_pos)
                   | row_hit(r_s1, alloc_req_pos)
                   | row_hit(r_s2, alloc_req_pos);

  assign alloc_req_ready          = ~w_blocked;
  assign alloc_valid_fdt_in       = alloc_req_valid & alloc_req_ready;
  assign alloc_id_fdt_in          = alloc_valid_fdt_in ? alloc_req_id          : '0;
  assign alloc_pos_fdt_in         = alloc_valid_fdt_in ? alloc_req_pos         : '0;
  assign alloc_size_fdt_in        = alloc_valid_fdt_in ? alloc_req_size        : '0;
  assign alloc_origin_size_fdt_in = alloc_valid_fdt_in ? alloc_req_origin_size : '0;

  assign at_tree_update_en           = w_issue;
  assign at_tree_update_column_idx   = w_issue ? w_head.column_idx   : '0;
  assign at_tree_update_row_idx      = w_issue ? w_head.row_idx      : '0;
  assign at_tree_update_bit_sequence = w_issue ? w_head.bit_sequence : '0;

  assign sched_busy = w_queued | r_s1.valid | r_s2.valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (alloc_req_valid && !alloc_req_ready && !(&r_stall_cnt)) begin
      r_stall_cnt <= r_stall_cnt + STALL_CNT_WIDTH'(1);
    end
  end

  assign alloc_stall_cnt = r_stall_cnt;

endmodule
